// File: rtl/tx_arbiter_pkg.sv
// rtl/tx_arbiter_pkg.sv - shared state encodings, default line terminator and helpers for tx_arbiter
//
// Contents:
//   arb_state_t        3-bit FSM encoding ST_ARB..ST_WAIT_LO
//   DEFAULT_LOCK_CHAR  line terminator that releases a line lock (also used by the console driver)
//   onehot8_to_idx     index of the set bit in an up-to-8-bit one-hot vector
package tx_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_ARB     = 3'd0,
        ST_TAKE    = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_WAIT_LO = 3'd4
    } arb_state_t;

    localparam logic [7:0] DEFAULT_LOCK_CHAR = 8'h0A;

    function automatic logic [2:0] onehot8_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// rtl/tx_arbiter_rr_pick.sv - combinational round-robin picker: first request at or after a start index
//
// Ports:
//   req     in  NREQ  request vector
//   start   in  3     index where the search begins (must be < NREQ)
//   winner  out NREQ  one-hot winner, zero when nothing requests
//   found   out 1     some request was found
module rr_pick #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      start,
    output logic [NREQ-1:0] winner,
    output logic            found
);

    logic [7:0] req_pad;
    logic [7:0] win_pad;
    logic [3:0] idx;

    assign req_pad = 8'(req);
    assign winner  = win_pad[NREQ-1:0];

    // start < NREQ <= 8, so start + k stays below 2*NREQ and one subtraction wraps it.
    always_comb begin
        win_pad = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = 4'(start) + 4'(k);
            if (idx >= 4'(NREQ)) begin
                idx = idx - 4'(NREQ);
            end
            if (!found && req_pad[idx[2:0]]) begin
                win_pad[idx[2:0]] = 1'b1;
                found             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - round-robin arbiter with line locking in front of serial_tx
//
// Ports:
//   clk100     in  1       system clock
//   reset      in  1       asynchronous active-high reset
//   req_valid  in  NREQ    requester i has a character on its slice
//   req_data   in  8*NREQ  requester i data at [8i+7:8i]
//   req_ready  out NREQ    one-hot, registered; transfer when valid & ready
//   grant      out NREQ    one-hot owner of the transmitter, zero in ARB
//   locked     out 1       line lock held by current/last owner
//   tx_data    out 8       character to serial_tx, held between transfers
//   tx_start   out 1       one-cycle start pulse to serial_tx
//   tx_busy    in  1       serial_tx is shifting
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter bit          LOCK_EN   = 1'b1,
    parameter logic [7:0]  LOCK_CHAR = DEFAULT_LOCK_CHAR,
    parameter logic [15:0] IDLE_TO   = 16'd50000,
    parameter int unsigned BUSY_WAIT = 3
) (
    input  logic              clk100,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic              locked,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy
);

    arb_state_t  state;
    arb_state_t  state_nxt;

    logic [2:0]  owner;
    logic [2:0]  last_owner;
    logic [2:0]  lock_owner;
    logic [15:0] idle_cnt;
    logic [7:0]  busy_cnt;

    logic [7:0]  valid_pad;
    logic [63:0] data_pad;
    logic [7:0]  elig_pad;
    logic [2:0]  rr_start;
    logic [NREQ-1:0] pick_onehot;
    logic        pick_found;
    logic [2:0]  pick_idx;
    logic        owner_valid;
    logic [7:0]  owner_data;
    logic        idle_count_en;

    assign valid_pad   = 8'(req_valid);
    assign data_pad    = 64'(req_data);
    assign owner_valid = valid_pad[owner];
    assign owner_data  = data_pad[{owner, 3'b000} +: 8];
    assign rr_start    = (last_owner == 3'(NREQ - 1)) ? 3'd0 : last_owner + 3'd1;
    assign pick_idx    = onehot8_to_idx(8'(pick_onehot));

    // A held lock narrows the eligible set to the lock owner alone.
    always_comb begin
        elig_pad = valid_pad;
        if (locked) begin
            elig_pad             = '0;
            elig_pad[lock_owner] = valid_pad[lock_owner];
        end
    end

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req    (elig_pad[NREQ-1:0]),
        .start  (rr_start),
        .winner (pick_onehot),
        .found  (pick_found)
    );

    assign idle_count_en = LOCK_EN && (state == ST_ARB) && locked && !valid_pad[lock_owner];

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state <= ST_ARB;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ARB: begin
                if (pick_found) begin
                    state_nxt = ST_TAKE;
                end
            end
            ST_TAKE: begin
                state_nxt = owner_valid ? ST_START : ST_ARB;
            end
            ST_START: begin
                state_nxt = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                // The timeout guards against a busy pulse that never shows up.
                if (tx_busy || (busy_cnt == 8'(BUSY_WAIT - 1))) begin
                    state_nxt = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    state_nxt = ST_ARB;
                end
            end
            default: begin
                state_nxt = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            owner      <= '0;
            last_owner <= 3'(NREQ - 1);
            lock_owner <= '0;
            locked     <= 1'b0;
            idle_cnt   <= '0;
            busy_cnt   <= '0;
            req_ready  <= '0;
            grant      <= '0;
            tx_data    <= 8'h00;
            tx_start   <= 1'b0;
        end else begin
            req_ready <= '0;
            tx_start  <= 1'b0;

            if (state == ST_ARB && pick_found) begin
                owner     <= pick_idx;
                req_ready <= pick_onehot;
                grant     <= pick_onehot;
            end

            if (state == ST_TAKE) begin
                if (owner_valid) begin
                    tx_data    <= owner_data;
                    last_owner <= owner;
                    tx_start   <= 1'b1;
                    if (LOCK_EN) begin
                        if (owner_data == LOCK_CHAR) begin
                            locked <= 1'b0;
                        end else begin
                            locked     <= 1'b1;
                            lock_owner <= owner;
                        end
                    end
                end else begin
                    grant <= '0;
                end
            end

            if (state == ST_WAIT_LO && !tx_busy) begin
                grant <= '0;
            end

            busy_cnt <= (state == ST_WAIT_HI) ? busy_cnt + 8'd1 : 8'd0;

            // Release on the ARB cycle whose increment would bring the count to
            // IDLE_TO, so the next ARB cycle already arbitrates unlocked.
            if (idle_count_en) begin
                if (idle_cnt >= IDLE_TO - 16'd1) begin
                    locked   <= 1'b0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 16'd1;
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// tb/tb_tx_arbiter.sv - self-checking bench for tx_arbiter (locking and non-locking instances)
module tb_tx_arbiter;

    localparam int NREQ = 4;

    logic clk100 = 1'b0;
    logic reset  = 1'b1;

    logic [NREQ-1:0]   rv0 = '0, rv1 = '0;
    logic [8*NREQ-1:0] rd0 = '0, rd1 = '0;
    logic [NREQ-1:0]   rr0, rr1, g0, g1;
    logic              lk0, lk1, ts0, ts1;
    logic [7:0]        td0, td1;
    logic              tb0 = 1'b0, tb1 = 1'b0;

    always #5 clk100 = ~clk100;

    tx_arbiter #(.NREQ(NREQ), .LOCK_EN(1'b1), .LOCK_CHAR(8'h0A), .IDLE_TO(16'd10), .BUSY_WAIT(3)) dut_lock (
        .clk100(clk100), .reset(reset), .req_valid(rv0), .req_data(rd0), .req_ready(rr0),
        .grant(g0), .locked(lk0), .tx_data(td0), .tx_start(ts0), .tx_busy(tb0)
    );

    tx_arbiter #(.NREQ(NREQ), .LOCK_EN(1'b0), .LOCK_CHAR(8'h0A), .IDLE_TO(16'd10), .BUSY_WAIT(3)) dut_rr (
        .clk100(clk100), .reset(reset), .req_valid(rv1), .req_data(rd1), .req_ready(rr1),
        .grant(g1), .locked(lk1), .tx_data(td1), .tx_start(ts1), .tx_busy(tb1)
    );

    int n_checks = 0;
    int n_errors = 0;

    int busy_len [2];

    logic [7:0] qd [NREQ][16];
    int qh [NREQ];
    int qt [NREQ];

    int m_last, m_locked, m_lock_owner;

    int obs_idx [64];
    int obs_lk  [64];
    int gaps    [64];
    int nobs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NREQ-1:0] f_ready(input int d);  return d ? rr1 : rr0; endfunction
    function automatic logic [NREQ-1:0] f_grant(input int d);  return d ? g1 : g0;   endfunction
    function automatic logic [NREQ-1:0] f_valid(input int d);  return d ? rv1 : rv0; endfunction
    function automatic logic            f_locked(input int d); return d ? lk1 : lk0; endfunction
    function automatic logic            f_start(input int d);  return d ? ts1 : ts0; endfunction
    function automatic logic [7:0]      f_txd(input int d);    return d ? td1 : td0; endfunction

    function automatic int oh_idx(input logic [NREQ-1:0] oh);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (oh[i]) r = i;
        return r;
    endfunction

    function automatic bit all_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < NREQ; i++) if (qh[i] < qt[i]) e = 1'b0;
        return e;
    endfunction

    task automatic push(input int i, input logic [7:0] b);
        qd[i][qt[i]] = b;
        qt[i]++;
    endtask

    task automatic drive_reqs(input int d);
        logic [NREQ-1:0]   v;
        logic [8*NREQ-1:0] dat;
        v = '0;
        dat = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (qh[i] < qt[i]) begin
                v[i] = 1'b1;
                dat[8*i +: 8] = qd[i][qh[i]];
            end
        end
        if (d == 0) begin rv0 = v; rd0 = dat; end
        else        begin rv1 = v; rd1 = dat; end
    endtask

    // Who should get the next character: the lock owner while it still has data,
    // otherwise the first non-empty queue after the last sender. A lock owner with
    // nothing left loses the lock through the idle timeout.
    function automatic int model_pick(input int lock_en);
        if (lock_en != 0 && m_locked != 0) begin
            if (qh[m_lock_owner] < qt[m_lock_owner]) return m_lock_owner;
            m_locked = 0;
        end
        for (int k = 1; k <= NREQ; k++) begin
            if (qh[(m_last + k) % NREQ] < qt[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic busy_model(input int d);
        forever begin
            @(posedge clk100); #1;
            if (f_start(d) && busy_len[d] > 0) begin
                if (d == 0) tb0 = 1'b1; else tb1 = 1'b1;
                repeat (busy_len[d]) @(posedge clk100);
                #1;
                if (d == 0) tb0 = 1'b0; else tb1 = 1'b0;
            end
        end
    endtask

    initial busy_model(0);
    initial busy_model(1);

    task automatic do_reset();
        reset = 1'b1;
        rv0 = '0; rv1 = '0; rd0 = '0; rd1 = '0;
        for (int i = 0; i < NREQ; i++) begin qh[i] = 0; qt[i] = 0; end
        m_last = NREQ - 1;
        m_locked = 0;
        m_lock_owner = 0;
        repeat (6) @(posedge clk100);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_stream(input int d, input int lock_en);
        int cyc, pend, gap, run, pred, idx;
        logic [7:0] eb;
        logic [NREQ-1:0] rdy, v;
        bit done;
        cyc = 0; pend = -1; gap = 0; run = 0; nobs = 0; done = 1'b0; eb = '0;
        drive_reqs(d);
        while (!done && cyc < 3000) begin
            @(posedge clk100); #1;
            cyc++;
            if (pend >= 0) begin
                qh[pend]++;
                pend = -1;
                drive_reqs(d);
            end
            if (f_grant(d) != 0) begin
                run++;
            end else begin
                if (run > 0 && busy_len[d] == 0) chk("dead_char_cycles", run, 6);
                run = 0;
                gap++;
            end
            rdy = f_ready(d);
            chk("ready_onehot0", 32'($onehot0(rdy)), 1);
            if (rdy != 0) begin
                idx = oh_idx(rdy);
                pred = model_pick(lock_en);
                chk("winner", idx, pred);
                v = f_valid(d);
                chk("ready_with_valid", 32'(v[idx]), 1);
                chk("grant_eq_ready", 32'(f_grant(d)), 32'(rdy));
                eb = qd[idx][qh[idx]];
                if (lock_en != 0) begin
                    if (eb == 8'h0A) m_locked = 0;
                    else begin m_locked = 1; m_lock_owner = idx; end
                end
                m_last = idx;
                obs_idx[nobs] = idx;
                gaps[nobs] = gap;
                nobs++;
                gap = 0;
                pend = idx;
            end
            if (f_start(d)) begin
                chk("tx_data", 32'(f_txd(d)), 32'(eb));
                chk("locked", 32'(f_locked(d)), m_locked);
                if (nobs > 0) obs_lk[nobs-1] = int'(f_locked(d));
            end
            if (pend < 0 && all_empty() && f_grant(d) == 0) done = 1'b1;
        end
        chk("stream_done", 32'(done), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        busy_len[0] = 3;
        busy_len[1] = 3;

        // reset values
        reset = 1'b1;
        #12;
        chk("rst_ready_async", 32'(rr0), 0);
        do_reset();
        chk("rst_ready", 32'(rr0), 0);
        chk("rst_grant", 32'(g0), 0);
        chk("rst_start", 32'(ts0), 0);
        chk("rst_txdata", 32'(td0), 0);
        chk("rst_locked", 32'(lk0), 0);
        chk("rst_grant_rr", 32'(g1), 0);

        // single source, req 0 sends 8'h41
        @(posedge clk100); #1;
        rv1 = 4'b0001; rd1 = 32'h0000_0041;
        @(posedge clk100); #1;
        chk("ss_ready", 32'(rr1), 32'h1);
        chk("ss_grant", 32'(g1), 32'h1);
        @(posedge clk100); #1;
        rv1 = '0;
        chk("ss_start", 32'(ts1), 1);
        chk("ss_txdata", 32'(td1), 32'h41);
        chk("ss_ready_drop", 32'(rr1), 0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk100); #1;
            if (g1 == 0) ok = 1'b1;
        end
        chk("ss_grant_release", 32'(ok), 1);
        chk("ss_busy_low", 32'(tb1), 0);
        chk("ss_locked_off", 32'(lk1), 0);

        // plain round-robin, LOCK_EN=0
        do_reset();
        push(0, 8'h10); push(0, 8'h14); push(1, 8'h11); push(2, 8'h12); push(3, 8'h13);
        run_stream(1, 0);
        chk("rr_count", nobs, 5);
        for (int i = 0; i < 5; i++) chk("rr_order", obs_idx[i], (i == 4) ? 0 : i);

        // line lock: req 1 sends A B LF while req 2 waits
        do_reset();
        push(1, 8'h41); push(1, 8'h42); push(1, 8'h0A); push(2, 8'h55); push(2, 8'h56);
        run_stream(0, 1);
        chk("lock_count", nobs, 5);
        chk("lock_o0", obs_idx[0], 1);
        chk("lock_o1", obs_idx[1], 1);
        chk("lock_o2", obs_idx[2], 1);
        chk("lock_o3", obs_idx[3], 2);
        chk("lock_after_A", obs_lk[0], 1);
        chk("lock_after_LF", obs_lk[2], 0);

        // idle timeout, IDLE_TO=10
        do_reset();
        push(1, 8'h41); push(3, 8'h33);
        run_stream(0, 1);
        chk("idle_count", nobs, 2);
        chk("idle_o0", obs_idx[0], 1);
        chk("idle_o1", obs_idx[1], 3);
        chk("idle_gap", gaps[1], 11);
        chk("idle_lock_req3", obs_lk[1], 1);

        // dead transmitter
        do_reset();
        busy_len[0] = 0;
        push(0, 8'h01); push(0, 8'h02); push(2, 8'h0A);
        run_stream(0, 1);
        chk("dead_count", nobs, 3);
        busy_len[0] = 3;

        // randomized traffic on both instances
        for (int r = 0; r < 8; r++) begin
            do_reset();
            busy_len[r % 2] = $urandom_range(0, 4);
            for (int i = 0; i < NREQ; i++) begin
                int n;
                n = $urandom_range(0, 5);
                for (int j = 0; j < n; j++) begin
                    logic [7:0] b;
                    b = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom_range(0, 255));
                    push(i, b);
                end
            end
            run_stream(r % 2, (r % 2 == 0) ? 1 : 0);
        end
        busy_len[0] = 3;
        busy_len[1] = 3;

        // reset in WAIT_LO
        do_reset();
        busy_len[0] = 4;
        rv0 = 4'b0100; rd0 = 32'h0077_0000;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk100); #1;
            if (ts0) ok = 1'b1;
        end
        chk("mid_start_seen", 32'(ok), 1);
        rv0 = '0;
        @(posedge clk100); #1;
        @(posedge clk100); #1;
        chk("mid_grant_pre", 32'(g0), 32'h4);
        chk("mid_locked_pre", 32'(lk0), 1);
        chk("mid_busy_pre", 32'(tb0), 1);
        @(negedge clk100);
        reset = 1'b1;
        #1;
        chk("mid_grant_async", 32'(g0), 0);
        chk("mid_ready_async", 32'(rr0), 0);
        chk("mid_start_async", 32'(ts0), 0);
        chk("mid_locked_async", 32'(lk0), 0);
        do_reset();
        push(0, 8'h10); push(2, 8'h20);
        run_stream(0, 1);
        chk("post_rst_first", obs_idx[0], 0);
        chk("post_rst_second", obs_idx[1], 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
